// File: rtl/rvfi_dmem_model.sv
`default_nettype none
// ============================================================================
//  Module      : rvfi_dmem_model
//  Description : Single-port word-aligned data-memory responder with a
//                programmable response latency. Each response is mirrored
//                as a one-cycle RVFI mem-field transaction record.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvfi_dmem_model #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH_LOG2 = 4,
  parameter logic [XLEN-1:0] BASE_ADDR  = 32'h0000_1000,
  parameter int              LATENCY    = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN/8-1:0] req_rmask,
  input  logic [XLEN/8-1:0] req_wmask,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mon_valid,
  output logic [XLEN-1:0]   mon_mem_addr,
  output logic [XLEN/8-1:0] mon_mem_rmask,
  output logic [XLEN/8-1:0] mon_mem_wmask,
  output logic [XLEN-1:0]   mon_mem_rdata,
  output logic [XLEN-1:0]   mon_mem_wdata
);

  localparam int NB     = XLEN / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int IDX_W  = DEPTH_LOG2;
  localparam int HI_LSB = OFF_W + IDX_W;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_BUSY = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  localparam bit         c_HAS_LAT  = (LATENCY > 0);
  localparam logic [3:0] c_LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q;
  logic [XLEN-1:0] mem_q [DEPTH];

  // Transaction captured at acceptance, waiting out the latency
  logic [XLEN-1:0] pend_addr_q, pend_rdata_q, pend_wdata_q;
  logic [NB-1:0]   pend_rmask_q, pend_wmask_q;
  logic            pend_err_q;

  // Presented response / record; only change when a response is entered
  logic [XLEN-1:0] out_addr_q, out_rdata_q, out_wdata_q;
  logic [NB-1:0]   out_rmask_q, out_wmask_q;
  logic            out_err_q;

  logic            w_ready, w_accept, w_fault, w_enter_resp;
  logic [IDX_W-1:0] w_idx;
  logic [XLEN-1:0] w_word, w_rdata, w_wdata;
  logic [NB-1:0]   w_rmask, w_wmask;

  // Address decode: misaligned or outside the window is a fault
  assign w_fault = (req_addr[OFF_W-1:0] != '0) ||
                   (req_addr[XLEN-1:HI_LSB] != BASE_ADDR[XLEN-1:HI_LSB]);
  assign w_idx    = req_addr[HI_LSB-1:OFF_W];
  assign w_word   = mem_q[w_idx];
  assign w_accept = req_valid && w_ready;

  // Effective masks and lane-masked data; a fault suppresses every lane
  always_comb begin
    w_rmask = w_fault ? '0 : req_rmask;
    w_wmask = w_fault ? '0 : req_wmask;
    w_rdata = '0;
    w_wdata = '0;
    for (int b = 0; b < NB; b++) begin
      if (w_rmask[b]) w_rdata[8*b +: 8] = w_word[8*b +: 8];
      if (w_wmask[b]) w_wdata[8*b +: 8] = req_wdata[8*b +: 8];
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= c_ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: if (w_accept) state_d = c_HAS_LAT ? c_ST_BUSY : c_ST_RESP;
      c_ST_BUSY: if (cnt_q == 4'd0) state_d = c_ST_RESP;
      c_ST_RESP: if (rsp_ready) state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  // FSM outputs; req_ready is gated by reset so it reads low while held
  always_comb begin
    w_ready   = (state_q == c_ST_IDLE) && resetn;
    rsp_valid = (state_q == c_ST_RESP);
    mon_valid = (state_q == c_ST_RESP) && rsp_ready;
  end

  assign req_ready    = w_ready;
  assign w_enter_resp = (state_d == c_ST_RESP) && (state_q != c_ST_RESP);

  // Latency down-counter, loaded at acceptance
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 4'd0;
    end else if (w_accept) begin
      cnt_q <= c_LAT_LOAD;
    end else if (state_q == c_ST_BUSY && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Storage: cleared on reset, written per lane on the acceptance edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_accept && !w_fault) begin
      for (int b = 0; b < NB; b++) begin
        if (req_wmask[b]) mem_q[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Capture the transaction (pre-write read data) at acceptance
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_addr_q  <= '0;
      pend_rdata_q <= '0;
      pend_wdata_q <= '0;
      pend_rmask_q <= '0;
      pend_wmask_q <= '0;
      pend_err_q   <= 1'b0;
    end else if (w_accept) begin
      pend_addr_q  <= req_addr;
      pend_rdata_q <= w_rdata;
      pend_wdata_q <= w_wdata;
      pend_rmask_q <= w_rmask;
      pend_wmask_q <= w_wmask;
      pend_err_q   <= w_fault;
    end
  end

  // Load the presented response on entry to RESP; zero-latency takes it live
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_addr_q  <= '0;
      out_rdata_q <= '0;
      out_wdata_q <= '0;
      out_rmask_q <= '0;
      out_wmask_q <= '0;
      out_err_q   <= 1'b0;
    end else if (w_enter_resp) begin
      if (state_q == c_ST_IDLE) begin
        out_addr_q  <= req_addr;
        out_rdata_q <= w_rdata;
        out_wdata_q <= w_wdata;
        out_rmask_q <= w_rmask;
        out_wmask_q <= w_wmask;
        out_err_q   <= w_fault;
      end else begin
        out_addr_q  <= pend_addr_q;
        out_rdata_q <= pend_rdata_q;
        out_wdata_q <= pend_wdata_q;
        out_rmask_q <= pend_rmask_q;
        out_wmask_q <= pend_wmask_q;
        out_err_q   <= pend_err_q;
      end
    end
  end

  assign rsp_rdata     = out_rdata_q;
  assign rsp_err       = out_err_q;
  assign mon_mem_addr  = out_addr_q;
  assign mon_mem_rmask = out_rmask_q;
  assign mon_mem_wmask = out_wmask_q;
  assign mon_mem_rdata = out_rdata_q;
  assign mon_mem_wdata = out_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_dmem_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvfi_dmem_model
//  Description : Directed self-checking bench for rvfi_dmem_model with a
//                reference memory and an expected-response queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_dmem_model;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_rmask = '0;
  logic [3:0]  req_wmask = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mon_valid;
  logic [31:0] mon_mem_addr;
  logic [3:0]  mon_mem_rmask;
  logic [3:0]  mon_mem_wmask;
  logic [31:0] mon_mem_rdata;
  logic [31:0] mon_mem_wdata;

  rvfi_dmem_model #(
    .XLEN(32), .DEPTH_LOG2(4), .BASE_ADDR(32'h0000_1000), .LATENCY(2)
  ) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rmask(req_rmask), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mon_valid(mon_valid), .mon_mem_addr(mon_mem_addr),
    .mon_mem_rmask(mon_mem_rmask), .mon_mem_wmask(mon_mem_wmask),
    .mon_mem_rdata(mon_mem_rdata), .mon_mem_wdata(mon_mem_wdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl[16];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    sb.delete();
  endtask

  // Reference behaviour: window 0x1000..0x103F, old data returned, write committed
  task automatic push_exp(input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd);
    exp_t       e;
    logic       fault;
    logic [3:0] idx;
    fault = (a[1:0] != 2'b00) || ((a & 32'hFFFF_FFC0) != 32'h0000_1000);
    idx   = a[5:2];
    e.addr = a; e.err = fault; e.rdata = '0; e.wdata = '0; e.rmask = '0; e.wmask = '0;
    if (!fault) begin
      e.rmask = rm;
      e.wmask = wm;
      for (int b = 0; b < 4; b++)
        if (rm[b]) e.rdata[8*b +: 8] = mdl[idx][8*b +: 8];
      for (int b = 0; b < 4; b++)
        if (wm[b]) begin
          e.wdata[8*b +: 8]    = wd[8*b +: 8];
          mdl[idx][8*b +: 8]   = wd[8*b +: 8];
        end
    end
    sb.push_back(e);
  endtask

  // Present a request from a negedge; returns just after the accepting edge
  task automatic issue(input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd);
    int waited = 0;
    req_valid = 1'b1; req_addr = a; req_rmask = rm; req_wmask = wm; req_wdata = wd;
    push_exp(a, rm, wm, wd);
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 20) check("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait for the response, optionally apply backpressure, then handshake
  task automatic collect(input int hold);
    int          lat = 0;
    exp_t        e;
    logic [31:0] held;
    do begin
      @(negedge clock);
      lat++;
    end while (!rsp_valid && lat < 50);
    check("rsp_latency", lat, 32'd3);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, held);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_mon_valid", {31'd0, mon_valid}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("mon_valid_pulse", {31'd0, mon_valid}, 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      check("mon_addr", mon_mem_addr, e.addr);
      check("mon_rmask", {28'd0, mon_mem_rmask}, {28'd0, e.rmask});
      check("mon_wmask", {28'd0, mon_mem_wmask}, {28'd0, e.wmask});
      check("mon_rdata", mon_mem_rdata, e.rdata);
      check("mon_wdata", mon_mem_wdata, e.wdata);
    end
    @(negedge clock);
    rsp_ready = 1'b0;
    #1;
    check("post_mon_valid", {31'd0, mon_valid}, 32'd0);
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mon_valid", {31'd0, mon_valid}, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Full write, partial write, reads with varied masks
    issue(32'h1004, 4'h0, 4'hF, 32'hDEADBEEF); collect(0);
    issue(32'h1004, 4'h0, 4'h2, 32'h0000AA00); collect(0);
    issue(32'h1004, 4'hF, 4'h0, 32'h0);        collect(0);
    issue(32'h1004, 4'h1, 4'h0, 32'h0);        collect(0);
    // Combined read/write returns old word, then new word
    issue(32'h1004, 4'hF, 4'hF, 32'h12345678); collect(0);
    issue(32'h1004, 4'hF, 4'h0, 32'h0);        collect(0);
    // Faults: misaligned and out of window; memory untouched
    issue(32'h1002, 4'hF, 4'hF, 32'hFFFFFFFF); collect(0);
    issue(32'h1004, 4'hF, 4'h0, 32'h0);        collect(0);
    issue(32'h2000, 4'hF, 4'hF, 32'hFFFFFFFF); collect(0);
    // Zero masks: legal no-op at the top word of the window
    issue(32'h103C, 4'h0, 4'h0, 32'h55555555); collect(0);
    // Backpressure for five cycles
    issue(32'h1004, 4'hF, 4'h0, 32'h0);        collect(5);

    // Reset during BUSY after a write to 0x1008
    issue(32'h1008, 4'h0, 4'hF, 32'hCAFEF00D);
    @(negedge clock);
    check("busy_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    resetn = 1'b0;
    #1;
    model_reset();
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_mon_valid", {31'd0, mon_valid}, 32'd0);
    check("mid_rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    check("mid_rst_mon_addr",  mon_mem_addr, 32'd0);
    check("mid_rst_mon_wdata", mon_mem_wdata, 32'd0);
    check("mid_rst_mon_masks", {24'd0, mon_mem_rmask, mon_mem_wmask}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("post_rst_no_rsp", {30'd0, rsp_valid, mon_valid}, 32'd0);
    end
    issue(32'h1008, 4'hF, 4'h0, 32'h0);        collect(0);
    issue(32'h1004, 4'hF, 4'h0, 32'h0);        collect(0);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rvfi_dmem_model.md
Name: rvfi_dmem_model

Overview:
- Single-port data-memory responder for formal and simulation harnesses.
- Accepts word-aligned load/store requests from a core's data port over a valid/ready handshake.
- Returns read data after a programmable latency.
- Emits a one-cycle transaction record in RVFI mem-field format (addr, rmask, wmask, rdata, wdata) so the existing dmem consistency checkers can consume the model's traffic directly.

Parameters:
- XLEN, 32, data/address width; XLEN/8 byte lanes.
- DEPTH_LOG2, 4, log2 of storage words (default 16 words).
- BASE_ADDR, 32'h0000_1000, base byte address of the window; must be aligned to (XLEN/8)<<DEPTH_LOG2.
- LATENCY, 2, cycles spent in BUSY between request acceptance and response valid (0..15).

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  model can accept a request.
- req_addr  in  XLEN  byte address.
- req_rmask  in  XLEN/8  byte lanes to read.
- req_wmask  in  XLEN/8  byte lanes to write.
- req_wdata  in  XLEN  write data, lane-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  XLEN  read data; unread lanes are 0.
- rsp_err  out  1  access fault (misaligned or out of window).
- mon_valid  out  1  one-cycle transaction record strobe.
- mon_mem_addr  out  XLEN  request address.
- mon_mem_rmask  out  XLEN/8  effective read mask.
- mon_mem_wmask  out  XLEN/8  effective write mask.
- mon_mem_rdata  out  XLEN  same value as rsp_rdata.
- mon_mem_wdata  out  XLEN  req_wdata with unwritten lanes forced to 0.

Behaviour:
- Reset: resetn low asynchronously forces the FSM to IDLE and clears all storage words to 0. It also forces these outputs low: req_ready, rsp_valid, rsp_err, mon_valid, and all data/mask outputs. Reset mid-transaction discards that transaction; no response or monitor record is ever produced for it.
- FSM state IDLE:
  - req_ready=1.
  - On req_valid&&req_ready the request is accepted.
  - Transition: to BUSY if LATENCY>0, else directly to RESP on the next cycle.
- FSM state BUSY:
  - req_ready=0.
  - Down-counter loaded with LATENCY-1 at acceptance; decrements each cycle.
  - Transition: at 0 -> RESP.
- FSM state RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: mon_valid pulses for exactly that cycle and the FSM moves to IDLE.
  - req_ready rises the cycle after the handshake; back-to-back requests are not accepted in the handshake cycle.
- Decode at acceptance:
  - Fault if req_addr[log2(XLEN/8)-1:0]!=0, or req_addr bits above DEPTH_LOG2+log2(XLEN/8) differ from BASE_ADDR.
  - Word index = req_addr[DEPTH_LOG2+log2(XLEN/8)-1 : log2(XLEN/8)].
- Access semantics, all sampled at acceptance:
  - Read data captures the pre-write word, masked by req_rmask.
  - The write is committed in the same edge, per lane where req_wmask is set. A combined rmask/wmask request therefore returns old data (RVFI semantics).
- Fault:
  - No write occurs; rsp_rdata=0; rsp_err=1.
  - Monitor record: rmask=0, wmask=0, rdata=0, wdata=0, addr reported.
- Masks both zero: legal no-op; response with rdata=0, rsp_err=0; mon_valid still pulses with zero masks.
- rsp_rdata and the mon_* outputs hold their last values outside their valid cycles; only the strobes are guaranteed low.
- req_* inputs are ignored outside IDLE.
- Monitor consistency: for every mon_valid, mon_mem_rdata lanes in mon_mem_rmask equal the last value written to that byte. A dmem checker bound to the mon_* outputs must never fire.

Test Plan:
- Reset, then write: req_addr=0x1004, wmask=4'hF, wdata=0xDEADBEEF, rmask=0.
  -> rsp_valid exactly 3 cycles after acceptance (LATENCY=2).
  -> rsp_err=0; mon_mem_wmask=F, mon_mem_wdata=0xDEADBEEF.
- Partial write then read:
  - Write 0x1004 wmask=4'h2, wdata=0x0000AA00; then read rmask=4'hF.
  -> rsp_rdata=0xDEADAAEF.
  - Read again with rmask=4'h1.
  -> rsp_rdata=0x000000EF.
- Combined read/write at 0x1004: rmask=F, wmask=F, wdata=0x12345678.
  -> rsp_rdata=0xDEADAAEF (old word).
  -> A subsequent read returns 0x12345678.
- Faults:
  - req_addr=0x1002 -> rsp_err=1, rsp_rdata=0, memory unchanged.
  - req_addr=0x2000 -> rsp_err=1.
  - In both cases mon_mem_rmask=mon_mem_wmask=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  -> rsp_valid and rsp_rdata stable throughout; req_ready=0; mon_valid low.
  - Assert rsp_ready.
  -> mon_valid pulses once; req_ready=1 on the next cycle.
- Reset mid-op: drop resetn during BUSY after a write to 0x1008.
  -> All outputs 0 immediately; no rsp_valid/mon_valid after release.
  -> Read of 0x1008 returns 0.
